// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - splits 1/2/4/8-byte core accesses into word-aligned 32-bit memory beats
// Loads are reassembled from up to three beats and sign/zero-extended to BIT_COUNT.
module load_store_unit #(
  parameter int BIT_COUNT = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [1:0]           ReqSize,
  input  logic                 ReqUnsigned,
  input  logic [BIT_COUNT-1:0] ReqAdr,
  input  logic [BIT_COUNT-1:0] ReqWriteData,
  output logic                 RespValid,
  output logic                 RespError,
  output logic [BIT_COUNT-1:0] RespData,
  output logic                 MemEn,
  output logic                 MemWrite,
  output logic [3:0]           ByteEn,
  output logic [BIT_COUNT-1:0] MemAdr,
  output logic [31:0]          MemWriteData,
  input  logic [31:0]          MemReadData,
  input  logic                 MemReady
);

  if (BIT_COUNT != 32 && BIT_COUNT != 64) begin : g_bad_bit_count
    $error("load_store_unit: BIT_COUNT must be 32 or 64");
  end
  if (WORD_SIZE != 32) begin : g_bad_word_size
    $error("load_store_unit: WORD_SIZE must be 32");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t               state, state_next;
  logic [1:0]           beat;
  logic                 lat_write, lat_unsigned, lat_error;
  logic [1:0]           lat_size, lat_off;
  logic [BIT_COUNT-1:0] lat_base;
  logic [11:0]          lat_mask;
  logic [95:0]          lat_window, read_buf;

  logic [11:0]          size_mask, req_mask;
  logic [95:0]          req_window;
  logic                 req_error, last_beat;
  logic [3:0]           beat_en;
  logic [31:0]          beat_data;
  logic [63:0]          load_raw, load_ext;

  always_comb begin
    size_mask = 12'h001;
    case (ReqSize)
      2'd0: size_mask = 12'h001;
      2'd1: size_mask = 12'h003;
      2'd2: size_mask = 12'h00F;
      2'd3: size_mask = 12'h0FF;
    endcase
  end

  assign req_mask   = size_mask << ReqAdr[1:0];
  assign req_error  = (ReqSize == 2'd3) && (BIT_COUNT == 32);
  assign req_window = {{(96-BIT_COUNT){1'b0}}, ReqWriteData} << {ReqAdr[1:0], 3'b000};

  // The current beat is the last one when no enabled byte lies beyond it.
  always_comb begin
    last_beat = 1'b1;
    beat_en   = lat_mask[3:0];
    beat_data = lat_window[31:0];
    case (beat)
      2'd0: begin
        last_beat = (lat_mask[11:4] == 8'h00);
        beat_en   = lat_mask[3:0];
        beat_data = lat_window[31:0];
      end
      2'd1: begin
        last_beat = (lat_mask[11:8] == 4'h0);
        beat_en   = lat_mask[7:4];
        beat_data = lat_window[63:32];
      end
      default: begin
        last_beat = 1'b1;
        beat_en   = lat_mask[11:8];
        beat_data = lat_window[95:64];
      end
    endcase
  end

  always_comb begin
    load_raw = 64'(read_buf >> {lat_off, 3'b000});
    load_ext = load_raw;
    case (lat_size)
      2'd0:    load_ext = {{56{load_raw[7]  & ~lat_unsigned}}, load_raw[7:0]};
      2'd1:    load_ext = {{48{load_raw[15] & ~lat_unsigned}}, load_raw[15:0]};
      2'd2:    load_ext = {{32{load_raw[31] & ~lat_unsigned}}, load_raw[31:0]};
      default: load_ext = load_raw;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat         <= 2'd0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_error    <= 1'b0;
      lat_size     <= 2'd0;
      lat_off      <= 2'd0;
      lat_base     <= '0;
      lat_mask     <= '0;
      lat_window   <= '0;
      read_buf     <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= 2'd0;
          if (ReqValid) begin
            lat_write    <= ReqWrite;
            lat_unsigned <= ReqUnsigned;
            lat_error    <= req_error;
            lat_size     <= ReqSize;
            lat_off      <= ReqAdr[1:0];
            lat_base     <= {ReqAdr[BIT_COUNT-1:2], 2'b00};
            lat_mask     <= req_mask;
            lat_window   <= req_window;
          end
        end
        ACCESS: begin
          if (MemReady) begin
            if (!lat_write) begin
              case (beat)
                2'd0:    read_buf[31:0]  <= MemReadData;
                2'd1:    read_buf[63:32] <= MemReadData;
                default: read_buf[95:64] <= MemReadData;
              endcase
            end
            beat <= beat + 2'd1;
          end
        end
        default: beat <= 2'd0;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    ReqReady     = 1'b0;
    RespValid    = 1'b0;
    RespError    = 1'b0;
    RespData     = '0;
    MemEn        = 1'b0;
    MemWrite     = 1'b0;
    ByteEn       = 4'h0;
    MemAdr       = '0;
    MemWriteData = 32'h0;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) state_next = req_error ? RESP : ACCESS;
      end
      ACCESS: begin
        MemEn        = 1'b1;
        MemWrite     = lat_write;
        ByteEn       = beat_en;
        MemAdr       = lat_base + BIT_COUNT'({beat, 2'b00});
        MemWriteData = beat_data;
        if (MemReady && last_beat) state_next = RESP;
      end
      RESP: begin
        RespValid  = 1'b1;
        RespError  = lat_error;
        RespData   = (lat_write || lat_error) ? '0 : BIT_COUNT'(load_ext);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
